// File: rtl/lifo_ext_if.sv
// Bus bundle for lifo_ext: request side driven by the master, status side by the stack.
// Handshake: a push (wrreq_i) or pop (rdreq_i) is a single-cycle request sampled on
// the rising edge; there is no ready -- refusals are reported through the sticky flags.
interface lifo_ext_if #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
);
  logic              clr_i;
  logic              wrreq_i;
  logic [DWIDTH-1:0] data_i;
  logic              rdreq_i;
  logic [DWIDTH-1:0] q_o;
  logic              empty_o;
  logic              full_o;
  logic              almost_empty_o;
  logic              almost_full_o;
  logic [AWIDTH:0]   usedw_o;
  logic              overflow_o;
  logic              underflow_o;

  modport master (
    output clr_i, wrreq_i, data_i, rdreq_i,
    input  q_o, empty_o, full_o, almost_empty_o, almost_full_o,
           usedw_o, overflow_o, underflow_o
  );

  modport slave (
    input  clr_i, wrreq_i, data_i, rdreq_i,
    output q_o, empty_o, full_o, almost_empty_o, almost_full_o,
           usedw_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/lifo_ext.sv
// Single-clock LIFO with top-replace, programmable almost flags, sticky errors,
// synchronous clear and an optional show-ahead output register.
module lifo_ext #(
  parameter int DWIDTH    = 8,
  parameter int AWIDTH    = 4,
  parameter int AF_LEVEL  = 12,
  parameter int AE_LEVEL  = 2,
  parameter bit SHOWAHEAD = 1'b0
) (
  input logic       clk_i,
  input logic       srst_i,
  lifo_ext_if.slave bus
);
  localparam int DEPTH = 1 << AWIDTH;

  logic [DWIDTH-1:0] mem_q [DEPTH];

  logic [AWIDTH:0]   usedw_q, usedw_d;
  logic [DWIDTH-1:0] q_q, q_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              empty_q, full_q, ae_q, af_q;

  logic              is_empty, is_full;
  logic [AWIDTH-1:0] wr_addr, top_addr, below_addr, mem_waddr;
  logic              mem_we;

  always_comb begin
    is_empty   = (usedw_q == '0);
    is_full    = (usedw_q == (AWIDTH+1)'(DEPTH));
    wr_addr    = usedw_q[AWIDTH-1:0];
    top_addr   = wr_addr - AWIDTH'(1);
    below_addr = wr_addr - AWIDTH'(2);

    usedw_d   = usedw_q;
    q_d       = q_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;

    if (bus.clr_i) begin
      usedw_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      case ({bus.wrreq_i, bus.rdreq_i})
        2'b10: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            mem_we  = 1'b1;
            usedw_d = usedw_q + 1'b1;
            if (SHOWAHEAD) q_d = bus.data_i;
          end
        end
        2'b01: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else begin
            usedw_d = usedw_q - 1'b1;
            // Show-ahead exposes the word beneath the popped one; an emptied stack keeps the last top.
            if (!SHOWAHEAD)              q_d = mem_q[top_addr];
            else if (usedw_q >= 2'd2)    q_d = mem_q[below_addr];
          end
        end
        2'b11: begin
          mem_we = 1'b1;
          if (is_empty) begin
            usedw_d = usedw_q + 1'b1;
            if (SHOWAHEAD) q_d = bus.data_i;
          end else begin
            mem_waddr = top_addr;
            q_d       = SHOWAHEAD ? bus.data_i : mem_q[top_addr];
          end
        end
        default: ;
      endcase
    end

    if (srst_i) mem_we = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[mem_waddr] <= bus.data_i;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      usedw_q <= '0;
      q_q     <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ae_q    <= 1'b1;
      af_q    <= 1'b0;
    end else begin
      usedw_q <= usedw_d;
      q_q     <= q_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      empty_q <= (usedw_d == '0);
      full_q  <= (usedw_d == (AWIDTH+1)'(DEPTH));
      ae_q    <= (usedw_d <= (AWIDTH+1)'(AE_LEVEL));
      af_q    <= (usedw_d >= (AWIDTH+1)'(AF_LEVEL));
    end
  end

  assign bus.q_o            = q_q;
  assign bus.usedw_o        = usedw_q;
  assign bus.empty_o        = empty_q;
  assign bus.full_o         = full_q;
  assign bus.almost_empty_o = ae_q;
  assign bus.almost_full_o  = af_q;
  assign bus.overflow_o     = ovf_q;
  assign bus.underflow_o    = unf_q;
endmodule

// File: tb/tb_lifo_ext.sv
// Directed bench for lifo_ext: registered-output instance plus a show-ahead instance.
module tb_lifo_ext;
  logic clk = 1'b0;
  logic srst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lifo_ext_if #(.DWIDTH(8), .AWIDTH(4)) bus ();
  lifo_ext_if #(.DWIDTH(8), .AWIDTH(4)) bus_sa ();

  lifo_ext #(.DWIDTH(8), .AWIDTH(4), .AF_LEVEL(12), .AE_LEVEL(2), .SHOWAHEAD(1'b0))
    dut (.clk_i(clk), .srst_i(srst), .bus(bus));
  lifo_ext #(.DWIDTH(8), .AWIDTH(4), .AF_LEVEL(12), .AE_LEVEL(2), .SHOWAHEAD(1'b1))
    dut_sa (.clk_i(clk), .srst_i(srst), .bus(bus_sa));

  // Inputs change #1 after a rising edge; outputs are sampled at that same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic w, input logic [7:0] d, input logic r);
    bus.clr_i = c; bus.wrreq_i = w; bus.data_i = d; bus.rdreq_i = r;
  endtask

  task automatic drive_sa(input logic w, input logic [7:0] d, input logic r);
    bus_sa.clr_i = 1'b0; bus_sa.wrreq_i = w; bus_sa.data_i = d; bus_sa.rdreq_i = r;
  endtask

  task automatic test_reset();
    srst = 1'b1; drive(1'b0, 1'b0, 8'h00, 1'b0); drive_sa(1'b0, 8'h00, 1'b0);
    step(); step();
    srst = 1'b0;
    step();
    checks++;
    if ({bus.usedw_o, bus.empty_o, bus.full_o, bus.almost_empty_o, bus.almost_full_o,
         bus.overflow_o, bus.underflow_o, bus.q_o} !== {5'd0, 6'b101000, 8'h00}) begin
      failures++;
      $display("FAIL reset_state: usedw=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b q=%h, need 0 1 0 1 0 0 0 00",
               bus.usedw_o, bus.empty_o, bus.full_o, bus.almost_empty_o, bus.almost_full_o,
               bus.overflow_o, bus.underflow_o, bus.q_o);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      logic [3:0] exp_flags;
      drive(1'b0, 1'b1, 8'(i), 1'b0); step();
      exp_flags = {1'b0, (i + 1) == 16, (i + 1) <= 2, (i + 1) >= 12};
      checks++;
      if (bus.usedw_o !== 5'(i + 1) ||
          {bus.empty_o, bus.full_o, bus.almost_empty_o, bus.almost_full_o} !== exp_flags) begin
        failures++;
        $display("FAIL fill_%0d: usedw=%0d flags(e,f,ae,af)=%b, need %0d %b", i, bus.usedw_o,
                 {bus.empty_o, bus.full_o, bus.almost_empty_o, bus.almost_full_o}, i + 1, exp_flags);
      end
    end
    for (int i = 0; i < 16; i++) begin
      logic [3:0] exp_flags;
      int n;
      n = 15 - i;
      drive(1'b0, 1'b0, 8'h00, 1'b1); step();
      exp_flags = {n == 0, 1'b0, n <= 2, n >= 12};
      checks++;
      if (bus.q_o !== 8'(15 - i) || bus.usedw_o !== 5'(n) ||
          {bus.empty_o, bus.full_o, bus.almost_empty_o, bus.almost_full_o} !== exp_flags) begin
        failures++;
        $display("FAIL drain_%0d: q=%h usedw=%0d flags=%b, need %h %0d %b", i, bus.q_o,
                 bus.usedw_o, {bus.empty_o, bus.full_o, bus.almost_empty_o, bus.almost_full_o},
                 8'(15 - i), n, exp_flags);
      end
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 16; i++) begin drive(1'b0, 1'b1, 8'(i), 1'b0); step(); end
    drive(1'b0, 1'b1, 8'hAA, 1'b0); step();
    checks++;
    if (bus.usedw_o !== 5'd16 || bus.overflow_o !== 1'b1 || bus.full_o !== 1'b1) begin
      failures++;
      $display("FAIL overflow_set: usedw=%0d ov=%b full=%b, need 16 1 1", bus.usedw_o, bus.overflow_o, bus.full_o);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0); step();
    checks++;
    if (bus.overflow_o !== 1'b1) begin
      failures++;
      $display("FAIL overflow_sticky: ov=%b, need 1", bus.overflow_o);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1); step();
    checks++;
    if (bus.q_o !== 8'h0F || bus.usedw_o !== 5'd15 || bus.overflow_o !== 1'b1) begin
      failures++;
      $display("FAIL overflow_pop: q=%h usedw=%0d ov=%b, need 0f 15 1", bus.q_o, bus.usedw_o, bus.overflow_o);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0); step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_replace();
    logic [7:0] vals [5] = '{8'h30, 8'h31, 8'h32, 8'h34, 8'h33};
    for (int i = 0; i < 5; i++) begin drive(1'b0, 1'b1, vals[i], 1'b0); step(); end
    drive(1'b0, 1'b1, 8'h77, 1'b1); step();
    checks++;
    if (bus.q_o !== 8'h33 || bus.usedw_o !== 5'd5 || bus.overflow_o !== 1'b0 || bus.underflow_o !== 1'b0) begin
      failures++;
      $display("FAIL replace: q=%h usedw=%0d ov=%b un=%b, need 33 5 0 0", bus.q_o, bus.usedw_o,
               bus.overflow_o, bus.underflow_o);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1); step();
    checks++;
    if (bus.q_o !== 8'h77 || bus.usedw_o !== 5'd4) begin
      failures++;
      $display("FAIL replace_pop: q=%h usedw=%0d, need 77 4", bus.q_o, bus.usedw_o);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1); step();
    checks++;
    if (bus.q_o !== 8'h34) begin
      failures++;
      $display("FAIL replace_below: q=%h, need 34", bus.q_o);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0); step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_underflow();
    // q_o still holds 0x34 from the previous scenario; clear keeps it.
    drive(1'b0, 1'b0, 8'h00, 1'b1); step();
    checks++;
    if (bus.underflow_o !== 1'b1 || bus.q_o !== 8'h34 || bus.usedw_o !== 5'd0) begin
      failures++;
      $display("FAIL underflow_set: un=%b q=%h usedw=%0d, need 1 34 0", bus.underflow_o, bus.q_o, bus.usedw_o);
    end
    drive(1'b1, 1'b0, 8'h00, 1'b0); step();
    drive(1'b0, 1'b1, 8'h5A, 1'b1); step();
    checks++;
    if (bus.usedw_o !== 5'd1 || bus.underflow_o !== 1'b0 || bus.q_o !== 8'h34 || bus.empty_o !== 1'b0) begin
      failures++;
      $display("FAIL push_pop_empty: usedw=%0d un=%b q=%h e=%b, need 1 0 34 0", bus.usedw_o,
               bus.underflow_o, bus.q_o, bus.empty_o);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b1); step();
    checks++;
    if (bus.q_o !== 8'h5A || bus.empty_o !== 1'b1) begin
      failures++;
      $display("FAIL push_pop_empty_pop: q=%h e=%b, need 5a 1", bus.q_o, bus.empty_o);
    end
    drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_clear_reset();
    drive(1'b0, 1'b0, 8'h00, 1'b1); step();
    for (int i = 0; i < 16; i++) begin drive(1'b0, 1'b1, 8'(i), 1'b0); step(); end
    drive(1'b0, 1'b1, 8'hEE, 1'b0); step();
    for (int i = 0; i < 7; i++) begin drive(1'b0, 1'b0, 8'h00, 1'b1); step(); end
    checks++;
    if (bus.usedw_o !== 5'd9 || bus.overflow_o !== 1'b1 || bus.underflow_o !== 1'b1 || bus.q_o !== 8'h09) begin
      failures++;
      $display("FAIL pre_clear: usedw=%0d ov=%b un=%b q=%h, need 9 1 1 09", bus.usedw_o,
               bus.overflow_o, bus.underflow_o, bus.q_o);
    end
    drive(1'b1, 1'b1, 8'hC3, 1'b0); step();
    checks++;
    if (bus.usedw_o !== 5'd0 || bus.empty_o !== 1'b1 || bus.almost_empty_o !== 1'b1 ||
        bus.almost_full_o !== 1'b0 || bus.overflow_o !== 1'b0 || bus.underflow_o !== 1'b0 || bus.q_o !== 8'h09) begin
      failures++;
      $display("FAIL clear: usedw=%0d e=%b ae=%b af=%b ov=%b un=%b q=%h, need 0 1 1 0 0 0 09", bus.usedw_o,
               bus.empty_o, bus.almost_empty_o, bus.almost_full_o, bus.overflow_o, bus.underflow_o, bus.q_o);
    end
    for (int i = 0; i < 7; i++) begin drive(1'b0, 1'b1, 8'h40 + 8'(i), 1'b0); step(); end
    drive(1'b0, 1'b0, 8'h00, 1'b1); srst = 1'b1; step();
    srst = 1'b0; drive(1'b0, 1'b0, 8'h00, 1'b0);
    checks++;
    if ({bus.usedw_o, bus.empty_o, bus.full_o, bus.almost_empty_o, bus.almost_full_o,
         bus.overflow_o, bus.underflow_o, bus.q_o} !== {5'd0, 6'b101000, 8'h00}) begin
      failures++;
      $display("FAIL reset_during_pop: usedw=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b q=%h, need 0 1 0 1 0 0 0 00",
               bus.usedw_o, bus.empty_o, bus.full_o, bus.almost_empty_o, bus.almost_full_o,
               bus.overflow_o, bus.underflow_o, bus.q_o);
    end
  endtask

  task automatic test_showahead();
    checks++;
    if (bus_sa.q_o !== 8'h00 || bus_sa.empty_o !== 1'b1) begin
      failures++;
      $display("FAIL sa_reset: q=%h e=%b, need 00 1", bus_sa.q_o, bus_sa.empty_o);
    end
    drive_sa(1'b1, 8'h11, 1'b0); step();
    checks++;
    if (bus_sa.q_o !== 8'h11) begin
      failures++;
      $display("FAIL sa_push1: q=%h, need 11", bus_sa.q_o);
    end
    drive_sa(1'b1, 8'h22, 1'b0); step();
    drive_sa(1'b0, 8'h00, 1'b0); step();
    checks++;
    if (bus_sa.q_o !== 8'h22 || bus_sa.usedw_o !== 5'd2) begin
      failures++;
      $display("FAIL sa_push2: q=%h usedw=%0d, need 22 2", bus_sa.q_o, bus_sa.usedw_o);
    end
    drive_sa(1'b1, 8'h99, 1'b1); step();
    checks++;
    if (bus_sa.q_o !== 8'h99 || bus_sa.usedw_o !== 5'd2) begin
      failures++;
      $display("FAIL sa_replace: q=%h usedw=%0d, need 99 2", bus_sa.q_o, bus_sa.usedw_o);
    end
    drive_sa(1'b0, 8'h00, 1'b1); step();
    checks++;
    if (bus_sa.q_o !== 8'h11 || bus_sa.usedw_o !== 5'd1) begin
      failures++;
      $display("FAIL sa_pop1: q=%h usedw=%0d, need 11 1", bus_sa.q_o, bus_sa.usedw_o);
    end
    drive_sa(1'b0, 8'h00, 1'b1); step();
    drive_sa(1'b0, 8'h00, 1'b0);
    checks++;
    if (bus_sa.q_o !== 8'h11 || bus_sa.empty_o !== 1'b1 || bus_sa.underflow_o !== 1'b0) begin
      failures++;
      $display("FAIL sa_pop2: q=%h e=%b un=%b, need 11 1 0", bus_sa.q_o, bus_sa.empty_o, bus_sa.underflow_o);
    end
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    drive_sa(1'b0, 8'h00, 1'b0);
    #1;
    test_reset();
    test_fill_drain();
    test_overflow();
    test_replace();
    test_underflow();
    test_clear_reset();
    test_showahead();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
